// File: rtl/data_mem_responder_pkg.sv
// ----------------------------------------------------------------------------
// data_mem_responder_pkg
// Shared definitions for the data memory responder:
//   - state_e               : responder FSM states (IDLE / WAIT / RESP)
//   - DEFAULT_DEPTH_WORDS   : default number of 32-bit storage words
//   - DEFAULT_WAIT_CYCLES   : default wait states between accept and response
//   - CNT_W                 : width of the wait-state counter (covers 0..15)
//   - addr_error()          : misalignment / out-of-range check for a byte address
// ----------------------------------------------------------------------------
package data_mem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int DEFAULT_DEPTH_WORDS = 64;
    localparam int DEFAULT_WAIT_CYCLES = 2;
    localparam int CNT_W               = 4;

    // A request is in error when it is not word aligned or its word index
    // falls beyond the implemented storage. The full 30-bit index is compared
    // so high address bits can never alias onto a real word.
    function automatic logic addr_error(input logic [31:0] addr, input int unsigned depth);
        logic [31:0] word_idx;
        word_idx   = {2'b00, addr[31:2]};
        addr_error = (addr[1:0] != 2'b00) || (word_idx >= 32'(depth));
    endfunction

endpackage

// File: rtl/data_mem_responder_mem_array.sv
// ----------------------------------------------------------------------------
// mem_array
// Word storage for the data memory responder.
// Ports:
//   clk    in  : clock, writes on rising edge
//   rst_n  in  : asynchronous active-low clear of every word
//   we     in  : write enable
//   waddr  in  : write word index
//   wdata  in  : write data
//   raddr  in  : read word index
//   rdata  out : combinational read data at raddr
// ----------------------------------------------------------------------------
module mem_array #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem_r [DEPTH];

    // Storage words: cleared on reset, single synchronous write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 32'h0000_0000;
            end
        end else if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // DEPTH is a power of two, so every raddr value addresses a real word.
    assign rdata = mem_r[raddr];

endmodule

// File: rtl/data_mem_responder.sv
// ----------------------------------------------------------------------------
// data_mem_responder
// Single-outstanding load/store responder in front of a word memory.
// A request is accepted in IDLE, held for WAIT_CYCLES wait states, and
// answered with a one-cycle response pulse. Stores commit on the edge that
// leaves the response cycle; erroneous requests never touch storage.
// Ports:
//   clk        in  : clock
//   reset      in  : asynchronous active-low reset
//   req_valid  in  : request present
//   req_ready  out : responder idle and able to accept
//   req_write  in  : 1 = store, 0 = load
//   req_addr   in  : byte address
//   req_wdata  in  : store data
//   rsp_valid  out : one-cycle response pulse
//   rsp_rdata  out : load data (0 for stores and errors)
//   rsp_err    out : misaligned or out-of-range request
//   busy       out : a request is outstanding
// ----------------------------------------------------------------------------
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] WAIT_LOAD =
        (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : {CNT_W{1'b0}};

    state_e           state_r;
    logic [CNT_W-1:0] wait_cnt_r;
    logic             cap_write_r;
    logic [31:0]      cap_addr_r;
    logic [31:0]      cap_wdata_r;

    logic             sel_write_s;
    logic [31:0]      sel_addr_s;
    logic             sel_err_s;
    logic [31:0]      load_data_s;
    logic             mem_we_s;
    logic [31:0]      mem_rdata_s;

    // Select the request being answered: live inputs in IDLE (needed when
    // WAIT_CYCLES=0 and the response is formed at the handshake edge),
    // otherwise the captured request.
    always_comb begin
        sel_write_s = 1'b0;
        sel_addr_s  = 32'h0000_0000;
        if (state_r == ST_IDLE) begin
            sel_write_s = req_write;
            sel_addr_s  = req_addr;
        end else begin
            sel_write_s = cap_write_r;
            sel_addr_s  = cap_addr_r;
        end
    end

    // Response data and store enable derived from the selected request.
    always_comb begin
        sel_err_s = addr_error(sel_addr_s, DEPTH_WORDS);
        if (!sel_write_s && !sel_err_s) begin
            load_data_s = mem_rdata_s;
        end else begin
            load_data_s = 32'h0000_0000;
        end
        mem_we_s = (state_r == ST_RESP) && cap_write_r
                   && !addr_error(cap_addr_r, DEPTH_WORDS);
    end

    mem_array #(
        .DEPTH (DEPTH_WORDS),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .rst_n (reset),
        .we    (mem_we_s),
        .waddr (cap_addr_r[AW+1:2]),
        .wdata (cap_wdata_r),
        .raddr (sel_addr_s[AW+1:2]),
        .rdata (mem_rdata_s)
    );

    // Responder FSM with registered handshake and response outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            wait_cnt_r  <= {CNT_W{1'b0}};
            cap_write_r <= 1'b0;
            cap_addr_r  <= 32'h0000_0000;
            cap_wdata_r <= 32'h0000_0000;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_rdata   <= 32'h0000_0000;
            busy        <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        cap_write_r <= req_write;
                        cap_addr_r  <= req_addr;
                        cap_wdata_r <= req_wdata;
                        req_ready   <= 1'b0;
                        busy        <= 1'b1;
                        if (WAIT_CYCLES == 0) begin
                            state_r   <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= sel_err_s;
                            rsp_rdata <= load_data_s;
                        end else begin
                            state_r    <= ST_WAIT;
                            wait_cnt_r <= WAIT_LOAD;
                        end
                    end else begin
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt_r == {CNT_W{1'b0}}) begin
                        state_r   <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= sel_err_s;
                        rsp_rdata <= load_data_s;
                    end else begin
                        wait_cnt_r <= wait_cnt_r - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    // The store (if any) commits on this edge via mem_we_s.
                    state_r   <= ST_IDLE;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= 32'h0000_0000;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    wait_cnt_r <= {CNT_W{1'b0}};
                    req_ready  <= 1'b1;
                    busy       <= 1'b0;
                    rsp_valid  <= 1'b0;
                    rsp_err    <= 1'b0;
                    rsp_rdata  <= 32'h0000_0000;
                end
            endcase
        end
    end

endmodule
